// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch-stage PC sequencer: FSM state encoding and
// default PC width / reset address.
package fetch_pkg;

    localparam int unsigned PC_W_DEF = 16;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;

    typedef enum logic [1:0] {
        StBoot   = 2'd0,
        StRun    = 2'd1,
        StHalted = 2'd2,
        StFault  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// PC-width register with asynchronous active-low reset to a configurable
// value and a synchronous load enable.
module pc_reg #(
    parameter int unsigned PC_W = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [PC_W-1:0] d,
    output logic [PC_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_PC;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencer: next-PC mux, +2 adder, stall-pending redirect and
// BOOT/RUN/HALTED/FAULT FSM. Define PC_ALIGN_CHECK_EN to fault on odd redirect targets.
module fetch_pc_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned PC_W = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            halt,
    input  logic            jump_valid,
    input  logic [PC_W-1:0] jump_target,
    input  logic            jump_err,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] fetch_pc,
    output logic [PC_W-1:0] pc_plus_two,
    output logic            fetch_valid,
    output logic            halted,
    output logic            err
);

    fetch_state_e    state_q, state_d;
    logic            pend_valid_q, pend_valid_d;
    logic [PC_W-1:0] pend_target;
    logic            pc_load, pend_load;
    logic [PC_W-1:0] pc_d, pend_d;
    logic            fresh_redirect, any_redirect;
    logic [PC_W-1:0] fresh_target, redirect_target;

    pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_fetch_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (pc_load),
        .d     (pc_d),
        .q     (fetch_pc)
    );

    pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pend_target (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (pend_load),
        .d     (pend_d),
        .q     (pend_target)
    );

    assign pc_plus_two = fetch_pc + PC_W'(2);

    // Redirects arriving this cycle; jump beats branch.
    always_comb begin
        fresh_redirect = jump_valid | branch_taken;
        fresh_target   = jump_valid ? jump_target : branch_target;
    end

    // A fresh redirect beats the one held over from a stall.
    always_comb begin
        any_redirect    = fresh_redirect | pend_valid_q;
        redirect_target = fresh_redirect ? fresh_target : pend_target;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StBoot;
            pend_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_load    = 1'b0;
        pend_d       = fresh_target;
        pc_load      = 1'b0;
        pc_d         = pc_plus_two;

        case (state_q)
            StBoot: begin
                state_d = StRun;
            end
            StRun: begin
                if (jump_valid && jump_err) begin
                    state_d = StFault;
                end else if (stall) begin
                    if (fresh_redirect) begin
                        pend_load    = 1'b1;
                        pend_valid_d = 1'b1;
                    end
                end else begin
                    pend_valid_d = 1'b0;
                    if (halt) begin
                        state_d = StHalted;
                    end else begin
`ifdef PC_ALIGN_CHECK_EN
                        if (any_redirect && redirect_target[0]) begin
                            state_d = StFault;
                        end else begin
                            pc_load = 1'b1;
                            pc_d    = any_redirect ? redirect_target : pc_plus_two;
                        end
`else
                        pc_load = 1'b1;
                        pc_d    = any_redirect ? redirect_target : pc_plus_two;
`endif
                    end
                end
            end
            default: begin
                // HALTED and FAULT hold everything until reset.
            end
        endcase
    end

    assign fetch_valid = (state_q == StRun);
    assign halted      = (state_q == StHalted);
    assign err         = (state_q == StFault);

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed self-checking bench for fetch_pc_ctrl; expected values are hand-computed.
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        halt = 1'b0;
    logic        jump_valid = 1'b0;
    logic [15:0] jump_target = '0;
    logic        jump_err = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = '0;
    logic [15:0] fetch_pc;
    logic [15:0] pc_plus_two;
    logic        fetch_valid;
    logic        halted;
    logic        err;

    int n_checks = 0;
    int n_pass = 0;

    fetch_pc_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .halt          (halt),
        .jump_valid    (jump_valid),
        .jump_target   (jump_target),
        .jump_err      (jump_err),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .fetch_pc      (fetch_pc),
        .pc_plus_two   (pc_plus_two),
        .fetch_valid   (fetch_valid),
        .halted        (halted),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; halt = 0; jump_valid = 0; jump_err = 0; branch_taken = 0;
        jump_target = '0; branch_target = '0;
    endtask

    // Reset, then leave BOOT so the next step is the first RUN-driven update.
    task automatic reset_to_run();
        clear_inputs();
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        step();
    endtask

    task automatic jump_to(input logic [15:0] addr);
        jump_valid = 1; jump_target = addr;
        step();
        jump_valid = 0;
    endtask

    initial begin
        // 1: reset and free-running sequence
        clear_inputs();
        #2;
        check_eq("rst_pc", fetch_pc, 16'h0000);
        check_eq("rst_valid", fetch_valid, 0);
        check_eq("rst_halted", halted, 0);
        check_eq("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1;
        check_eq("boot_valid", fetch_valid, 0);
        step();
        check_eq("run_pc0", fetch_pc, 16'h0000);
        check_eq("run_valid", fetch_valid, 1);
        check_eq("pc_plus_two", pc_plus_two, 16'h0002);
        step();
        check_eq("run_pc2", fetch_pc, 16'h0002);
        step();
        check_eq("run_pc4", fetch_pc, 16'h0004);

        // 2: jump beats branch
        jump_to(16'h0010);
        check_eq("jump_0010", fetch_pc, 16'h0010);
        jump_valid = 1; jump_target = 16'h0100;
        branch_taken = 1; branch_target = 16'h0200;
        step();
        clear_inputs();
        check_eq("jump_beats_branch", fetch_pc, 16'h0100);

        // 3: branch during stall is held and applied after the stall
        jump_to(16'h0020);
        check_eq("jump_0020", fetch_pc, 16'h0020);
        stall = 1;
        step();
        check_eq("stall1_hold", fetch_pc, 16'h0020);
        branch_taken = 1; branch_target = 16'h0040;
        step();
        branch_taken = 0;
        check_eq("stall2_hold", fetch_pc, 16'h0020);
        step();
        check_eq("stall3_hold", fetch_pc, 16'h0020);
        stall = 0;
        step();
        check_eq("pend_applied", fetch_pc, 16'h0040);
        step();
        check_eq("pend_cleared", fetch_pc, 16'h0042);

        // newest pending wins; fresh redirect beats pending; halt ignored while stalled
        stall = 1; branch_taken = 1; branch_target = 16'h0300;
        step();
        branch_taken = 0; jump_valid = 1; jump_target = 16'h0400; halt = 1;
        step();
        jump_valid = 0;
        check_eq("halt_in_stall_ignored", halted, 0);
        check_eq("stall_hold_0042", fetch_pc, 16'h0042);
        halt = 0; stall = 0;
        step();
        check_eq("newest_pending", fetch_pc, 16'h0400);
        stall = 1; branch_taken = 1; branch_target = 16'h0500;
        step();
        branch_taken = 0; stall = 0; jump_valid = 1; jump_target = 16'h0600;
        step();
        jump_valid = 0;
        check_eq("fresh_beats_pending", fetch_pc, 16'h0600);
        step();
        check_eq("after_fresh", fetch_pc, 16'h0602);

        // 4: wrap-around
        jump_to(16'hFFFE);
        step();
        check_eq("wrap_pc", fetch_pc, 16'h0000);
        check_eq("wrap_err", err, 0);

        // 5: jump fault during stall, sticky until reset
        jump_to(16'h0050);
        stall = 1; jump_valid = 1; jump_err = 1; jump_target = 16'h0070;
        step();
        clear_inputs();
        check_eq("fault_err", err, 1);
        check_eq("fault_valid", fetch_valid, 0);
        step();
        step();
        check_eq("fault_sticky", err, 1);
        check_eq("fault_pc_frozen", fetch_pc, 16'h0050);
        rst_n = 0;
        #1;
        check_eq("async_rst_pc", fetch_pc, 16'h0000);
        check_eq("async_rst_err", err, 0);

        // 6: halt freezes the PC
        reset_to_run();
        jump_to(16'h0030);
        halt = 1;
        step();
        halt = 0;
        check_eq("halted", halted, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("halt_pc_hold", fetch_pc, 16'h0030);
        end
        check_eq("halted_sticky", halted, 1);
        check_eq("halted_valid", fetch_valid, 0);

        // odd redirect target
        reset_to_run();
        jump_to(16'h0101);
`ifdef PC_ALIGN_CHECK_EN
        check_eq("align_err", err, 1);
        check_eq("align_pc", fetch_pc, 16'h0000);
`else
        check_eq("align_err", err, 0);
        check_eq("align_pc", fetch_pc, 16'h0101);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
